// File: rtl/pc_branch_unit_pkg.sv
// rtl/pc_branch_unit_pkg.sv - shared opcodes, FSM states, flag struct and flag-write classifier
package pc_branch_unit_pkg;

  localparam int PC_W_DEFAULT = 10;

  typedef enum logic [7:0] {
    OP_ADD  = 8'h00, OP_ADDC, OP_SUB, OP_SUBC, OP_LSL, OP_LSLC, OP_LSR, OP_LSRC,
    OP_ASR, OP_NEG, OP_AND, OP_OR, OP_CMP, OP_BLT, OP_BNE, OP_HALT,
    OP_IMME, OP_LW, OP_SW, OP_ALW, OP_ASW
  } op_code_e;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_HALT} state_e;

  typedef struct packed {
    logic c;
    logic n;
    logic z;
  } flags_t;

  typedef enum logic [1:0] {FC_NONE, FC_FULL, FC_NZ} flag_class_e;

  // CMP is NZ-only; the caller selects cmp_i instead of result_i as its source.
  function automatic flag_class_e flag_class(input logic [7:0] op);
    flag_class_e fc;
    case (op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC,
      OP_LSL, OP_LSLC, OP_LSR, OP_LSRC, OP_ASR: fc = FC_FULL;
      OP_NEG, OP_AND, OP_OR, OP_CMP:            fc = FC_NZ;
      default:                                  fc = FC_NONE;
    endcase
    return fc;
  endfunction

endpackage

// File: rtl/pc_branch_unit_cond_flags.sv
// rtl/pc_branch_unit_cond_flags.sv - architectural C/N/Z register and BLT/BNE condition
module cond_flags
  import pc_branch_unit_pkg::*;
(
  input  logic       CLK,
  input  logic       reset_n,
  input  logic       clear_i,
  input  logic       c_we_i,
  input  logic       nz_we_i,
  input  logic       c_i,
  input  logic [7:0] nz_src_i,
  input  logic       blt_i,
  input  logic       bne_i,
  output flags_t     flags_o,
  output logic       taken_o
);

  flags_t flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (clear_i) begin
      flags_d = '0;
    end else begin
      if (c_we_i) flags_d.c = c_i;
      if (nz_we_i) begin
        flags_d.n = nz_src_i[7];
        flags_d.z = (nz_src_i == 8'd0);
      end
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) flags_q <= '0;
    else          flags_q <= flags_d;
  end

  assign flags_o = flags_q;
  // Conditions read the registered flags: the previous instruction's result.
  assign taken_o = (blt_i & flags_q.n) | (bne_i & ~flags_q.z);

endmodule

// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - PC, branch/flush/halt FSM; optional cycle counter under PC_BRANCH_CYCLE_CNT_EN
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic            CLK,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic            valid_i,
  input  logic [7:0]      op_i,
  input  logic [7:0]      result_i,
  input  logic [7:0]      cmp_i,
  input  logic            carry_i,
  input  logic [PC_W-1:0] target_i,
  output logic [PC_W-1:0] pc_o,
  output logic            cin_o,
  output logic [2:0]      flags_o,
  output logic            flush_o,
  output logic            halted_o
`ifdef PC_BRANCH_CYCLE_CNT_EN
  ,
  output logic [15:0]     cycle_cnt_o
`endif
);

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic            flush_q;
  logic            halted_q;

  flags_t          flags;
  flag_class_e     fclass;
  logic            exec;
  logic            taken;

  assign exec   = (state_q == ST_RUN) && valid_i;
  assign fclass = flag_class(op_i);

  cond_flags u_cond_flags (
    .CLK      (CLK),
    .reset_n  (reset_n),
    .clear_i  ((state_q == ST_HALT) && start_i),
    .c_we_i   (exec && (fclass == FC_FULL)),
    .nz_we_i  (exec && (fclass != FC_NONE)),
    .c_i      (carry_i),
    .nz_src_i ((op_i == OP_CMP) ? cmp_i : result_i),
    .blt_i    (exec && (op_i == OP_BLT)),
    .bne_i    (exec && (op_i == OP_BNE)),
    .flags_o  (flags),
    .taken_o  (taken)
  );

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) state_q <= ST_RUN;
        end
        ST_RUN: begin
          if (valid_i) begin
            if (taken) begin
              pc_q    <= target_i;
              state_q <= ST_FLUSH;
              flush_q <= 1'b1;
            end else if (op_i == OP_HALT) begin
              state_q  <= ST_HALT;
              halted_q <= 1'b1;
            end else begin
              pc_q <= pc_q + PC_W'(1);
            end
          end
        end
        ST_FLUSH: begin
          state_q <= ST_RUN;
        end
        ST_HALT: begin
          if (start_i) begin
            state_q <= ST_RUN;
            pc_q    <= '0;
          end else begin
            halted_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign pc_o     = pc_q;
  assign flags_o  = flags;
  assign cin_o    = flags.c;
  assign flush_o  = flush_q;
  assign halted_o = halted_q;

`ifdef PC_BRANCH_CYCLE_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (start_i && ((state_q == ST_IDLE) || (state_q == ST_HALT))) begin
      cnt_q <= '0;
    end else if (((state_q == ST_RUN) || (state_q == ST_FLUSH)) && (cnt_q != 16'hFFFF)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cycle_cnt_o = cnt_q;
`endif

endmodule
